// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the writeback stage: widths, starvation limit and
// the write-source encoding used by the arbiter.
package writeback_arbiter_pkg;

    localparam int unsigned WB_DATA_WIDTH   = 32;
    localparam int unsigned WB_REG_COUNT    = 16;
    localparam int unsigned WB_REG_ADDR_W   = $clog2(WB_REG_COUNT);
    localparam int unsigned WB_FIFO_DEPTH   = 4;
    localparam int unsigned WB_STARVE_LIMIT = 3;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering {rd, data} load results for the writeback arbiter.
// Pushes while full and pops while empty are ignored.
module wb_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU results and buffered LSU loads onto the single
// register-file write port. ALU has priority; a starvation counter and the
// FIFO-full condition force the LSU head out.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = WB_DATA_WIDTH,
    parameter int unsigned REG_ADDR_W     = WB_REG_ADDR_W,
    parameter int unsigned LSU_FIFO_DEPTH = WB_FIFO_DEPTH,
    parameter int unsigned STARVE_LIMIT   = WB_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  rf_write_en,
    output logic [REG_ADDR_W-1:0] rf_write_reg,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic                  busy
);

    localparam int unsigned ENT_W    = REG_ADDR_W + DATA_WIDTH;
    localparam int unsigned CNT_W    = $clog2(LSU_FIFO_DEPTH) + 1;
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [ENT_W-1:0]      fifo_head;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [STARVE_W-1:0]   starve_cnt;
    logic                  force_lsu;
    logic                  sel_valid;
    wb_src_e               sel_src;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [DATA_WIDTH-1:0] head_data;

    wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (LSU_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({lsu_rd, lsu_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head_rd   = fifo_head[DATA_WIDTH +: REG_ADDR_W];
    assign head_data = fifo_head[DATA_WIDTH-1:0];
    assign fifo_push = lsu_valid && !fifo_full;
    assign lsu_ready = !fifo_full;
    assign force_lsu = !fifo_empty && (fifo_full || starve_cnt == STARVE_W'(STARVE_LIMIT));
    assign alu_ready = !force_lsu;
    assign busy      = (fifo_count != '0) || rf_write_en;

    // Per-cycle source selection in priority order: forced LSU, ALU, idle LSU.
    always_comb begin
        sel_valid = 1'b0;
        sel_src   = WB_SRC_ALU;
        fifo_pop  = 1'b0;
        if (force_lsu) begin
            sel_valid = 1'b1;
            sel_src   = WB_SRC_LSU;
            fifo_pop  = 1'b1;
        end else if (alu_valid) begin
            sel_valid = 1'b1;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_src   = WB_SRC_LSU;
            fifo_pop  = 1'b1;
        end
    end

    // Counts consecutive ALU wins while loads wait; cleared by any dequeue or an empty FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (fifo_pop || fifo_empty) begin
            starve_cnt <= '0;
        end else if (alu_valid && alu_ready && starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Registered write port; reg/data hold their last values when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_write_en   <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
        end else begin
            rf_write_en <= sel_valid;
            if (sel_valid) begin
                if (sel_src == WB_SRC_LSU) begin
                    rf_write_reg  <= head_rd;
                    rf_write_data <= head_data;
                end else begin
                    rf_write_reg  <= alu_rd;
                    rf_write_data <= alu_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed vector table, reset and
// wrap-around sequences, then random traffic against a queue-based model.
module tb_writeback_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [3:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_write_en;
    logic [3:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic        busy;

    writeback_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .lsu_valid     (lsu_valid),
        .lsu_ready     (lsu_ready),
        .lsu_rd        (lsu_rd),
        .lsu_data      (lsu_data),
        .rf_write_en   (rf_write_en),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        av;
        logic [3:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [3:0]  lrd;
        logic [31:0] ldat;
        logic        ar;
        logic        lr;
        logic        en;
        logic [3:0]  rg;
        logic [31:0] dt;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Reference model state: pending loads, ALU-win streak, expected write port.
    ent_t        q[$];
    int          starve;
    logic        m_en;
    logic [3:0]  m_reg;
    logic [31:0] m_data;

    logic s_ar, s_lr, s_busy;
    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        starve = 0;
        m_en   = 1'b0;
        m_reg  = '0;
        m_data = '0;
    endtask

    // One clock cycle: drive, check combinational outputs, advance model, check write port.
    task automatic cycle(input logic av, input logic [3:0] ard, input logic [31:0] adat,
                         input logic lv, input logic [3:0] lrd, input logic [31:0] ldat);
        bit   m_force;
        bit   was_full;
        ent_t e;
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = adat;
        lsu_valid = lv;
        lsu_rd    = lrd;
        lsu_data  = ldat;
        #2;
        s_ar     = alu_ready;
        s_lr     = lsu_ready;
        s_busy   = busy;
        was_full = (q.size() == DEPTH);
        m_force  = (q.size() != 0) && (was_full || starve == LIMIT);
        chk("alu_ready", 32'(alu_ready), 32'(!m_force));
        chk("lsu_ready", 32'(lsu_ready), 32'(!was_full));
        chk("busy", 32'(busy), 32'((q.size() != 0) || m_en));
        if (m_force || (!av && q.size() != 0)) begin
            e      = q.pop_front();
            m_en   = 1'b1;
            m_reg  = e.rd;
            m_data = e.data;
            starve = 0;
        end else if (av) begin
            m_en   = 1'b1;
            m_reg  = ard;
            m_data = adat;
            if (q.size() != 0 && starve < LIMIT) starve++;
        end else begin
            m_en = 1'b0;
        end
        if (lv && !was_full) begin
            e.rd   = lrd;
            e.data = ldat;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("rf_write_en", 32'(rf_write_en), 32'(m_en));
        chk("rf_write_reg", 32'(rf_write_reg), 32'(m_reg));
        chk("rf_write_data", rf_write_data, m_data);
    endtask

    function automatic vec_t mk(input logic av, input logic [3:0] ard, input logic [31:0] adat,
                                input logic lv, input logic [3:0] lrd, input logic [31:0] ldat,
                                input logic ar, input logic lr, input logic en,
                                input logic [3:0] rg, input logic [31:0] dt);
        vec_t v;
        v.av = av; v.ard = ard; v.adat = adat;
        v.lv = lv; v.lrd = lrd; v.ldat = ldat;
        v.ar = ar; v.lr = lr; v.en = en; v.rg = rg; v.dt = dt;
        return v;
    endfunction

    initial begin
        int got;
        int idle;

        // ALU only, then write_en drops with reg/data held.
        vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,     1, 1, 1, 5, 32'hDEADBEEF);
        vecs[1]  = mk(0, 0, 0,            0, 0, 0,     1, 1, 0, 5, 32'hDEADBEEF);
        // Simultaneous arrival: ALU first, load in the next idle cycle.
        vecs[2]  = mk(1, 1, 32'h11,       1, 2, 32'h22, 1, 1, 1, 1, 32'h11);
        vecs[3]  = mk(0, 0, 0,            0, 0, 0,     1, 1, 1, 2, 32'h22);
        vecs[4]  = mk(0, 0, 0,            0, 0, 0,     1, 1, 0, 2, 32'h22);
        // Starvation: three ALU wins with a waiting load, then a forced LSU write.
        vecs[5]  = mk(1, 3, 32'h30,       1, 7, 32'h77, 1, 1, 1, 3, 32'h30);
        vecs[6]  = mk(1, 3, 32'h31,       0, 0, 0,     1, 1, 1, 3, 32'h31);
        vecs[7]  = mk(1, 3, 32'h32,       0, 0, 0,     1, 1, 1, 3, 32'h32);
        vecs[8]  = mk(1, 3, 32'h33,       0, 0, 0,     1, 1, 1, 3, 32'h33);
        vecs[9]  = mk(1, 3, 32'h34,       0, 0, 0,     0, 1, 1, 7, 32'h77);
        vecs[10] = mk(1, 3, 32'h34,       0, 0, 0,     1, 1, 1, 3, 32'h34);
        vecs[11] = mk(0, 0, 0,            0, 0, 0,     1, 1, 0, 3, 32'h34);
        // Full FIFO while the ALU streams, forced drain, then remaining loads in order.
        vecs[12] = mk(1, 4, 32'h40,       1, 8,  32'h80, 1, 1, 1, 4, 32'h40);
        vecs[13] = mk(1, 4, 32'h41,       1, 9,  32'h81, 1, 1, 1, 4, 32'h41);
        vecs[14] = mk(1, 4, 32'h42,       1, 10, 32'h82, 1, 1, 1, 4, 32'h42);
        vecs[15] = mk(1, 4, 32'h43,       1, 11, 32'h83, 1, 1, 1, 4, 32'h43);
        vecs[16] = mk(1, 4, 32'h44,       1, 12, 32'hC0, 0, 0, 1, 8, 32'h80);
        vecs[17] = mk(1, 4, 32'h44,       0, 0,  0,      1, 1, 1, 4, 32'h44);
        vecs[18] = mk(0, 0, 0,            0, 0,  0,      1, 1, 1, 9, 32'h81);
        vecs[19] = mk(0, 0, 0,            0, 0,  0,      1, 1, 1, 10, 32'h82);
        vecs[20] = mk(0, 0, 0,            0, 0,  0,      1, 1, 1, 11, 32'h83);
        vecs[21] = mk(0, 0, 0,            0, 0,  0,      1, 1, 0, 11, 32'h83);

        // Reset state.
        reset     = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        model_reset();
        #2;
        chk("reset_alu_ready", 32'(alu_ready), 32'd1);
        chk("reset_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_en", 32'(rf_write_en), 32'd0);
        chk("reset_reg", 32'(rf_write_reg), 32'd0);
        chk("reset_data", rf_write_data, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 22; i++) begin
            cycle(vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].lv, vecs[i].lrd, vecs[i].ldat);
            chk($sformatf("vec%0d_alu_ready", i), 32'(s_ar), 32'(vecs[i].ar));
            chk($sformatf("vec%0d_lsu_ready", i), 32'(s_lr), 32'(vecs[i].lr));
            chk($sformatf("vec%0d_en", i), 32'(rf_write_en), 32'(vecs[i].en));
            chk($sformatf("vec%0d_reg", i), 32'(rf_write_reg), 32'(vecs[i].rg));
            chk($sformatf("vec%0d_data", i), rf_write_data, vecs[i].dt);
        end

        // Asynchronous reset with two loads buffered: nothing of them may be written.
        cycle(1, 6, 32'h60, 1, 13, 32'hD0);
        cycle(1, 6, 32'h61, 1, 14, 32'hD1);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("midreset_en", 32'(rf_write_en), 32'd0);
        chk("midreset_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("midreset_alu_ready", 32'(alu_ready), 32'd1);
        chk("midreset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0, 0, 0);
            chk("post_reset_no_write", 32'(rf_write_en), 32'd0);
        end

        // Wrap-around: ten loads, no ALU traffic, written in order with data intact.
        got = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0, 1, 4'(i), 32'(i * 3));
            if (rf_write_en) begin
                chk("wrap_reg", 32'(rf_write_reg), 32'(got));
                chk("wrap_data", rf_write_data, 32'(got * 3));
                got++;
            end
        end
        idle = 0;
        while (got < 10 && idle < 10) begin
            cycle(0, 0, 0, 0, 0, 0);
            idle++;
            if (rf_write_en) begin
                chk("wrap_reg", 32'(rf_write_reg), 32'(got));
                chk("wrap_data", rf_write_data, 32'(got * 3));
                got++;
            end
        end
        chk("wrap_count", 32'(got), 32'd10);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 9) < 5, 4'($urandom_range(0, 15)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
